// File: rtl/inc_pipe_pkg.sv
// inc_pipe_pkg: shared definitions for the pipelined incrementer.
//   - default WIDTH / CHUNK
//   - NSTAGE derivation (one pipeline stage per CHUNK-bit slice)
//   - stage-register field layout: {partial result, carry, valid}
//   - all-ones saturation constant for the default width
package inc_pipe_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CHUNK_DEF = 4;

  // Stage register layout, LSB first: valid, carry, then the WIDTH-bit
  // partial result (resolved low slices + untouched high slices).
  localparam int ST_VALID    = 0;
  localparam int ST_CARRY    = 1;
  localparam int ST_DATA_LSB = 2;

  localparam logic [WIDTH_DEF-1:0] SAT_ONES_DEF = {WIDTH_DEF{1'b1}};

  // Number of pipeline stages for a given width / slice size.
  function automatic int nstage(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Total width of one stage register.
  function automatic int stage_w(input int width);
    return width + ST_DATA_LSB;
  endfunction

endpackage

// File: rtl/half_adder.sv
// half_adder: single-bit half adder cell.
//   a, b : addends
//   s    : sum bit
//   c    : carry bit
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/inc_stage.sv
// inc_stage: combinational CHUNK-bit increment slice, a ripple chain of
// half adders that adds a single carry-in bit to the slice.
//   cin  : carry into the slice LSB
//   a    : slice operand
//   s    : slice result
//   cout : carry out of the slice MSB
module inc_stage
  import inc_pipe_pkg::*;
#(
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             cin,
  input  logic [CHUNK-1:0] a,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_ha
    half_adder u_ha (
      .a (a[i]),
      .b (c_s[i]),
      .s (s[i]),
      .c (c_s[i+1])
    );
  end

  assign cout = c_s[CHUNK];

endmodule

// File: rtl/increment_pipe.sv
// increment_pipe: pipelined S = A + inc (mod 2^WIDTH) with carry out Co.
// The carry chain is cut into CHUNK-bit slices, one slice resolved per
// stage, NSTAGE = WIDTH/CHUNK stages, valid/ready on both sides.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : input handshake (in_ready = out_ready | ~out_valid)
//   A, inc              : operand and 1-bit increment
//   out_valid, out_ready: output handshake
//   S, Co               : registered result and carry out of the MSB
// Build option INC_SATURATE_EN: on overflow S is forced to all ones in the
// final stage register (Co still 1); otherwise S wraps to 0.
module increment_pipe
  import inc_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic             inc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Co
);

  localparam int NSTAGE = nstage(WIDTH, CHUNK);
  localparam int SW     = stage_w(WIDTH);
`ifdef INC_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_ONES = {WIDTH{1'b1}};
`endif

  logic [NSTAGE-1:0][SW-1:0] stage_r;
  logic [NSTAGE-1:0][SW-1:0] stage_nxt_s;
  logic                      adv_s;

  // The whole pipe moves together; it only stops when the output is held.
  assign adv_s    = out_ready | ~out_valid;
  assign in_ready = adv_s;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    logic             src_valid_s;
    logic             src_carry_s;
    logic [WIDTH-1:0] src_data_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] data_s;
    logic [CHUNK-1:0] slice_s;
    logic             cout_s;

    if (k == 0) begin : g_first
      assign src_valid_s = in_valid;
      assign src_carry_s = inc;
      assign src_data_s  = A;
    end else begin : g_next
      assign src_valid_s = stage_r[k-1][ST_VALID];
      assign src_carry_s = stage_r[k-1][ST_CARRY];
      assign src_data_s  = stage_r[k-1][SW-1:ST_DATA_LSB];
    end

    inc_stage #(.CHUNK(CHUNK)) u_stage (
      .cin  (src_carry_s),
      .a    (src_data_s[k*CHUNK +: CHUNK]),
      .s    (slice_s),
      .cout (cout_s)
    );

    // Replace only this stage's slice; other bits travel unchanged.
    always_comb begin
      sum_s                    = src_data_s;
      sum_s[k*CHUNK +: CHUNK]  = slice_s;
    end

`ifdef INC_SATURATE_EN
    if (k == NSTAGE - 1) begin : g_sat
      assign data_s = cout_s ? SAT_ONES : sum_s;
    end else begin : g_pass
      assign data_s = sum_s;
    end
`else
    assign data_s = sum_s;
`endif

    assign stage_nxt_s[k] = {data_s, cout_s, src_valid_s};
  end

  // Stage registers: cleared on reset, loaded together on advance, else held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_r <= '0;
    end else if (adv_s) begin
      stage_r <= stage_nxt_s;
    end
  end

  assign out_valid = stage_r[NSTAGE-1][ST_VALID];
  assign Co        = stage_r[NSTAGE-1][ST_CARRY];
  assign S         = stage_r[NSTAGE-1][SW-1:ST_DATA_LSB];

endmodule
